// File: rtl/modred_stream_ctrl_if.sv
// rtl/modred_stream_ctrl_if.sv - config, operand, reducer and result signals of the reducer front-end
interface modred_stream_ctrl_if #(
  parameter int DATA_LENGTH = 64
) ();
  logic                   cfg_valid_i;
  logic [DATA_LENGTH-1:0] cfg_mod_i;
  logic                   mod_err_o;

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [DATA_LENGTH-1:0] in_data_i;

  logic                   red_start_o;
  logic [DATA_LENGTH-1:0] red_x_o;
  logic [DATA_LENGTH-1:0] red_m_o;
  logic [DATA_LENGTH-1:0] red_m_bl_o;
  logic [DATA_LENGTH-1:0] red_result_i;
  logic                   red_valid_i;

  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [DATA_LENGTH-1:0] out_data_o;

  logic                   busy_o;
  logic                   timeout_o;

  modport slave (
    input  cfg_valid_i, cfg_mod_i, in_valid_i, in_data_i,
           red_result_i, red_valid_i, out_ready_i,
    output mod_err_o, in_ready_o, red_start_o, red_x_o, red_m_o, red_m_bl_o,
           out_valid_o, out_data_o, busy_o, timeout_o
  );

  modport master (
    output cfg_valid_i, cfg_mod_i, in_valid_i, in_data_i,
           red_result_i, red_valid_i, out_ready_i,
    input  mod_err_o, in_ready_o, red_start_o, red_x_o, red_m_o, red_m_bl_o,
           out_valid_o, out_data_o, busy_o, timeout_o
  );
endinterface

// File: rtl/modred_stream_ctrl.sv
// rtl/modred_stream_ctrl.sv - operand FIFO, job sequencer and watchdog in front of the shift-add modular reducer
module modred_stream_ctrl #(
  parameter int DATA_LENGTH    = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  modred_stream_ctrl_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   abort;

  logic [DATA_LENGTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;

  logic                   mod_ok_q, mod_err_q;
  logic [DATA_LENGTH-1:0] red_m_q, red_m_bl_q;
  logic [DATA_LENGTH-1:0] red_x_q, out_data_q;
  logic                   start_hold_q;
  logic [WD_W-1:0]        wd_cnt_q;
  logic                   wd_expired;
  logic                   timeout_q;
  logic                   cfg_accept, out_fire, in_ready;

  function automatic logic [DATA_LENGTH-1:0] bit_len(input logic [DATA_LENGTH-1:0] v);
    logic [DATA_LENGTH-1:0] bl;
    bl = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (v[i]) bl = DATA_LENGTH'(i + 1);
    end
    return bl;
  endfunction

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_ready   = mod_ok_q & ~fifo_full;
  assign push       = bus.in_valid_i & in_ready;
  assign out_fire   = (state_q == ST_HOLD) & bus.out_ready_i;
  // A HOLD handshake pops the next operand directly so the reducer sees no idle gap.
  assign pop        = ~fifo_empty & ((state_q == ST_IDLE) | out_fire);
  assign cfg_accept = bus.cfg_valid_i & (state_q == ST_IDLE) & fifo_empty;
  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.red_valid_i) begin
          state_d = ST_HOLD;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_HOLD:  if (bus.out_ready_i) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mod_ok_q   <= 1'b0;
      mod_err_q  <= 1'b0;
      red_m_q    <= '0;
      red_m_bl_q <= '0;
    end else if (cfg_accept) begin
      red_m_q    <= bus.cfg_mod_i;
      red_m_bl_q <= bit_len(bus.cfg_mod_i);
      mod_ok_q   <= (bus.cfg_mod_i != '0);
      mod_err_q  <= (bus.cfg_mod_i == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      red_x_q      <= '0;
      out_data_q   <= '0;
      start_hold_q <= 1'b0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      // The reducer needs start for two cycles: ISSUE plus the first WAIT cycle.
      start_hold_q <= (state_q == ST_ISSUE);
      timeout_q    <= abort;
      if (pop) red_x_q <= fifo_mem[rd_ptr_q];
      if ((state_q == ST_WAIT) && bus.red_valid_i) out_data_q <= bus.red_result_i;
      if (state_q == ST_ISSUE) begin
        wd_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.mod_err_o   = mod_err_q;
  assign bus.red_m_o     = red_m_q;
  assign bus.red_m_bl_o  = red_m_bl_q;
  assign bus.red_x_o     = red_x_q;
  assign bus.red_start_o = (state_q == ST_ISSUE) | start_hold_q;
  assign bus.out_valid_o = (state_q == ST_HOLD);
  assign bus.out_data_o  = out_data_q;
  assign bus.busy_o      = (state_q != ST_IDLE) | ~fifo_empty;
  assign bus.timeout_o   = timeout_q;

endmodule
